// File: rtl/quot_res_recon_pkg.sv
// rtl/quot_res_recon_pkg.sv - shared types and constants for the divide-by-5 dividend reconstructor
package quot_res_recon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIV_CONST     = 5;
    localparam int REM_W         = 3;
    localparam int W_DEFAULT     = 64;
    localparam int DIGIT_DEFAULT = 4;
    localparam int NDIGITS       = W_DEFAULT / DIGIT_DEFAULT;

    // Number of quotient digits processed for a given width/digit size.
    function automatic int ndigits(input int w, input int d);
        return w / d;
    endfunction

endpackage

// File: rtl/quot_res_recon_if.sv
// rtl/quot_res_recon_if.sv - operand/result handshake bundle for quot_res_recon
interface quot_res_recon_if #(
    parameter int W = 64
) ();
    import quot_res_recon_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_q;
    logic [REM_W-1:0] in_r;
    logic             out_valid;
    logic             out_ready;
    logic [W+2:0]     out_x;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_q, in_r, out_ready,
        input  in_ready, out_valid, out_x, out_err, busy
    );

    modport slave (
        input  in_valid, in_q, in_r, out_ready,
        output in_ready, out_valid, out_x, out_err, busy
    );

endinterface

// File: rtl/quot_res_recon_mul5_digit.sv
// rtl/quot_res_recon_mul5_digit.sv - one digit of 5*d + carry-in, split into sum digit and carry-out
module mul5_digit
    import quot_res_recon_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] d,
    input  logic [REM_W-1:0] cin,
    output logic [DIGIT-1:0] s,
    output logic [REM_W-1:0] cout
);

    localparam logic [DIGIT+REM_W-1:0] K = (DIGIT + REM_W)'(DIV_CONST);

    logic [DIGIT+REM_W-1:0] t;

    // 5*(2^DIGIT-1)+7 < 8*2^DIGIT, so DIGIT+3 bits hold the product without loss.
    always_comb begin
        t    = ({{REM_W{1'b0}}, d} * K) + {{DIGIT{1'b0}}, cin};
        s    = t[DIGIT-1:0];
        cout = t[DIGIT+REM_W-1:DIGIT];
    end

endmodule

// File: rtl/quot_res_recon.sv
// rtl/quot_res_recon.sv - rebuilds x = 5*q + r one quotient digit per cycle
module quot_res_recon
    import quot_res_recon_pkg::*;
#(
    parameter int W     = 64,
    parameter int DIGIT = 4
) (
    input logic              clk,
    input logic              rst,
    quot_res_recon_if.slave  bus
);

    localparam int ND = ndigits(W, DIGIT);
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ND - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     q_q, q_d;
    logic [W+2:0]     res_q, res_d;
    logic [REM_W-1:0] carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;

    logic [DIGIT-1:0] dig_s;
    logic [REM_W-1:0] dig_c;

    // The quotient is shifted right each RUN cycle, so the current digit is always the low one.
    mul5_digit #(
        .DIGIT (DIGIT)
    ) u_mul5_digit (
        .d    (q_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_c)
    );

    // State register and datapath flops; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath: capture in IDLE, one digit per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    q_d     = bus.in_q;
                    carry_d = bus.in_r;
                    err_d   = (bus.in_r > REM_W'(DIV_CONST - 1));
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[DIGIT*idx_q +: DIGIT] = dig_s;
                q_d     = q_q >> DIGIT;
                carry_d = dig_c;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    res_d[W+2:W] = dig_c;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_x     = res_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_quot_res_recon.sv
// tb/tb_quot_res_recon.sv - self-checking bench for quot_res_recon
module tb_quot_res_recon;
    import quot_res_recon_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    quot_res_recon_if #(.W(W)) bus ();

    quot_res_recon #(.W(W), .DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        total_cnt++;
        if (act != exp) $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        else pass_cnt++;
    endtask

    // Model: one operation in flight; result visible from 16 edges after acceptance until taken.
    int          ecnt     = 0;
    bit          pending  = 1'b0;
    int          acc_edge = 0;
    logic [63:0] m_q      = '0;
    logic [2:0]  m_r      = '0;
    int          prev_acc = -1;
    int          last_acc = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 1'b0;
        end else begin
            ecnt++;
            if (pending) begin
                if ((ecnt - 1 >= acc_edge + 16) && bus.out_ready) pending = 1'b0;
            end else if (bus.in_valid) begin
                pending  = 1'b1;
                acc_edge = ecnt;
                m_q      = bus.in_q;
                m_r      = bus.in_r;
                prev_acc = last_acc;
                last_acc = ecnt;
            end
        end
    end

    bit          chk_en = 1'b0;
    bit          exp_v;
    logic [66:0] x_exp;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            exp_v = pending && (ecnt >= acc_edge + 16);
            chk1("in_ready", bus.in_ready, !pending);
            chk1("busy", bus.busy, pending);
            chk1("out_valid", bus.out_valid, exp_v);
            if (exp_v) begin
                x_exp = 67'(m_q) * 67'd5 + 67'(m_r);
                chk("out_x", bus.out_x, x_exp);
                chk1("out_err", bus.out_err, m_r > 3'd4);
                if (m_r <= 3'd4) begin
                    chk("rt_div", bus.out_x / 67'd5, 67'(m_q));
                    chk("rt_mod", bus.out_x % 67'd5, 67'(m_r));
                end
            end
        end
    end

    task automatic run_op(input logic [63:0] q, input logic [2:0] r, input logic [66:0] lit,
                          input logic lit_err, input int stall);
        int n;
        bit seen;
        chk1("pre_in_ready", bus.in_ready, 1'b1);
        bus.in_q      = q;
        bus.in_r      = r;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("model_x", 67'(m_q) * 67'd5 + 67'(m_r), lit);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chkint("latency", n, 16);
        chk("lit_x", bus.out_x, lit);
        chk1("lit_err", bus.out_err, lit_err);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = i[0];
            bus.in_q     = ~q;
            bus.in_r     = 3'd1;
            @(negedge clk);
            chk("stall_x", bus.out_x, lit);
            chk1("stall_in_ready", bus.in_ready, 1'b0);
            chk1("stall_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk1("post_valid", bus.out_valid, 1'b0);
        chk1("post_in_ready", bus.in_ready, 1'b1);
    endtask

    task automatic drain();
        int guard;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk1("drain_idle", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int guard;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_q      = '0;
        bus.in_r      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_out_err", bus.out_err, 1'b0);
        chk("rst_out_x", bus.out_x, 67'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op(64'h0, 3'd0, 67'd0, 1'b0, 0);
        run_op(64'h1, 3'd4, 67'd9, 1'b0, 0);
        run_op(64'h3333333333333333, 3'd0, 67'h0FFFFFFFFFFFFFFFF, 1'b0, 0);
        run_op(64'hFFFFFFFFFFFFFFFF, 3'd4, 67'h4FFFFFFFFFFFFFFFF, 1'b0, 0);
        run_op(64'h2, 3'd5, 67'd15, 1'b1, 0);
        run_op(64'h7, 3'd3, 67'd38, 1'b0, 0);
        run_op(64'h0, 3'd7, 67'd7, 1'b1, 0);
        run_op(64'h0123456789ABCDEF, 3'd2, 67'h05B05B05B05B05AD, 1'b0, 10);

        bus.in_q     = 64'h123456789ABCDEF0;
        bus.in_r     = 3'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("abort_in_ready", bus.in_ready, 1'b1);
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_out_x", bus.out_x, 67'd0);
        chk1("abort_out_err", bus.out_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk1("abort_no_valid", bus.out_valid, 1'b0);
        end
        run_op(64'd100, 3'd1, 67'd501, 1'b0, 0);

        bus.out_ready = 1'b1;
        bus.in_q      = 64'd5;
        bus.in_r      = 3'd0;
        bus.in_valid  = 1'b1;
        repeat (40) @(negedge clk);
        bus.in_valid = 1'b0;
        chkint("throughput", last_acc - prev_acc, 18);
        drain();

        for (int k = 0; k < 1500; k++) begin
            bus.in_q      = {$urandom, $urandom};
            bus.in_r      = 3'($urandom_range(0, 4));
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'($urandom_range(0, 1));
            guard = 0;
            while (!bus.in_ready && guard < 200) begin
                @(negedge clk);
                bus.out_ready = 1'($urandom_range(0, 1));
                guard++;
            end
            chk1("rand_accept", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        drain();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
